// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// a constant-evaluable ceiling-log2 used to size index and counter fields.
package uart_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Ceiling log2; returns the number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: starting just after 'ptr' and wrapping modulo N_REQ,
// report the first asserted request bit. Purely combinational.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    found,
    output logic [clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = clog2(N_REQ);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down to ptr+1 so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(ptr) + off) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte-stream requesters.
// Round-robin grants with packet atomicity: a grant is held until the
// requester flags its last byte or MAX_BURST bytes have been sent. Each byte
// is handed to uart_tx with a one-cycle tx_data_en strobe, and the next byte
// is only accepted after uart_tx reports tx_finish. A watchdog releases a
// grant that sits in ACCEPT or WAIT for TIMEOUT cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 1048576
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [8*N_REQ-1:0]      req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_data_en,
    output logic [7:0]              tx_data_in,
    input  logic                    tx_finish,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int GW   = clog2(N_REQ);
    localparam int WD_W = clog2(TIMEOUT + 1);

    // Watchdog fires in the TIMEOUT-th cycle spent in ACCEPT or WAIT.
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [8:0]      BURST_CAP = 9'(MAX_BURST);
    // Pointer starts at the top index so requester 0 wins the first scan.
    localparam logic [GW-1:0]   PTR_INIT  = GW'(N_REQ - 1);

    state_t           state;
    state_t           state_n;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    grant_n;
    logic [GW-1:0]    ptr;
    logic [GW-1:0]    ptr_n;
    logic [7:0]       data;
    logic [7:0]       data_n;
    logic             last;
    logic             last_n;
    logic [7:0]       burst;
    logic [7:0]       burst_n;
    logic [8:0]       burst_inc;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_n;
    logic             wd_expired;
    logic [N_REQ-1:0] ready_n;
    logic             en_n;
    logic             terr_n;

    logic             pick_found;
    logic [GW-1:0]    pick_idx;

    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Route the granted requester's byte, valid and last flag.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == GW'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    assign burst_inc  = {1'b0, burst} + 9'd1;
    assign wd_expired = (wd == WD_LAST);

    // Next-state, datapath capture and next registered outputs.
    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        data_n  = data;
        last_n  = last;
        burst_n = burst;
        wd_n    = wd;
        terr_n  = 1'b0;
        ready_n = '0;
        en_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_n = pick_idx;
                    burst_n = '0;
                    wd_n    = '0;
                    state_n = ST_ACCEPT;
                end
            end

            ST_ACCEPT: begin
                if (sel_valid) begin
                    data_n  = sel_data;
                    last_n  = sel_last;
                    state_n = ST_START;
                end else if (wd_expired) begin
                    terr_n  = 1'b1;
                    ptr_n   = grant;
                    state_n = ST_IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end

            ST_START: begin
                wd_n    = '0;
                state_n = ST_WAIT;
            end

            ST_WAIT: begin
                // A finish arriving in the expiry cycle takes priority.
                if (tx_finish) begin
                    burst_n = burst_inc[7:0];
                    if (last || (burst_inc == BURST_CAP)) begin
                        ptr_n   = grant;
                        state_n = ST_IDLE;
                    end else begin
                        wd_n    = '0;
                        state_n = ST_ACCEPT;
                    end
                end else if (wd_expired) begin
                    terr_n  = 1'b1;
                    ptr_n   = grant;
                    state_n = ST_IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state_n == ST_ACCEPT) begin
            ready_n[grant_n] = 1'b1;
        end
        en_n = (state_n == ST_START);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            ptr         <= PTR_INIT;
            data        <= '0;
            last        <= 1'b0;
            burst       <= '0;
            wd          <= '0;
            req_ready   <= '0;
            tx_data_en  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            ptr         <= ptr_n;
            data        <= data_n;
            last        <= last_n;
            burst       <= burst_n;
            wd          <= wd_n;
            req_ready   <= ready_n;
            tx_data_en  <= en_n;
            timeout_err <= terr_n;
        end
    end

    assign tx_data_in = data;
    assign grant_id   = grant;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester byte queues feed the DUT, a
// uart_tx stub answers each strobe with tx_finish after a programmable delay,
// and a monitor logs strobes, finishes and watchdog pulses by cycle number.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         clk_in;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         tx_data_en;
    logic [7:0]   tx_data_in;
    logic         tx_finish;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (8),
        .TIMEOUT   (64)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data_en  (tx_data_en),
        .tx_data_in  (tx_data_in),
        .tx_finish   (tx_finish),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int onehot_bad = 0;

    // Requester byte queues: {last, data}
    logic [8:0] srcq [N][$];

    typedef struct {
        int cyc;
        int gid;
        int data;
    } strobe_t;

    strobe_t str_q[$];
    int      fin_q[$];
    int      err_q[$];

    int stub_cnt = 0;
    int stub_delay = 10;
    bit stub_on = 1'b1;

    // Table of single-byte request sets: expected grants, first in MSB nibble.
    typedef struct packed {
        logic [3:0]  mask;
        logic [2:0]  n;
        logic [15:0] order;
    } vec_t;

    vec_t tbl [7];

    typedef struct {
        int gid;
        int data;
        int gap;
    } exp_t;

    exp_t exp_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_logs();
        str_q.delete();
        fin_q.delete();
        err_q.delete();
    endtask

    function automatic bit queues_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drain(input string name, input int maxc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            step(1);
            n++;
            done = (busy == 1'b0) && (stub_cnt == 0) && queues_empty();
        end
        step(2);
        check({name, "_drain"}, int'(done), 1);
    endtask

    task automatic wait_strobes(input string name, input int k, input int maxc);
        int n;
        n = 0;
        while (str_q.size() < k && n < maxc) begin
            step(1);
            n++;
        end
        check({name, "_strobe_wait"}, int'(str_q.size() >= k), 1);
    endtask

    // Requester model: pops a byte after its handshake, presents the next.
    initial begin
        logic [N-1:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk_in);
            fire = req_ready & req_valid;
            @(posedge clk_in);
            #2;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = srcq[i][0][7:0];
                    req_last[i]         = srcq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // uart_tx stub: tx_finish stub_delay cycles after each strobe.
    initial begin
        tx_finish = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            tx_finish = 1'b0;
            if (!busy) stub_cnt = 0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && stub_on) tx_finish = 1'b1;
            end
            if (tx_data_en) stub_cnt = stub_delay;
        end
    end

    // Mid-cycle monitor of DUT activity.
    always @(negedge clk_in) begin
        if (tx_data_en) str_q.push_back('{cyc: cyc, gid: int'(grant_id), data: int'(tx_data_in)});
        if (tx_finish) fin_q.push_back(cyc);
        if (timeout_err) err_q.push_back(cyc);
        if ($countones(req_ready) > 1) onehot_bad++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int t;
        int s;
        int g;

        tbl[0] = '{mask: 4'b1111, n: 3'd4, order: 16'h1230};
        tbl[1] = '{mask: 4'b1001, n: 3'd2, order: 16'h3000};
        tbl[2] = '{mask: 4'b0110, n: 3'd2, order: 16'h1200};
        tbl[3] = '{mask: 4'b0101, n: 3'd2, order: 16'h0200};
        tbl[4] = '{mask: 4'b1010, n: 3'd2, order: 16'h3100};
        tbl[5] = '{mask: 4'b0001, n: 3'd1, order: 16'h0000};
        tbl[6] = '{mask: 4'b1111, n: 3'd4, order: 16'h1230};

        // Reset values
        rst = 1'b1;
        step(3);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_tx_data_en", int'(tx_data_en), 0);
        check("rst_tx_data_in", int'(tx_data_in), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        step(2);

        // Single request: ready at t+1, strobe at t+2, finish at t+12
        clear_logs();
        t = cyc;
        srcq[0].push_back(9'h10E);
        step(1);
        check("single_ready_t1", int'(req_ready), 4'b0001);
        check("single_busy_t1", int'(busy), 1);
        step(1);
        check("single_strobe_t2", int'(tx_data_en), 1);
        check("single_data", int'(tx_data_in), 8'h0E);
        check("single_gid", int'(grant_id), 0);
        check("single_ready_t2", int'(req_ready), 0);
        step(1);
        check("single_strobe_len", int'(tx_data_en), 0);
        step(9);
        check("single_busy_t12", int'(busy), 1);
        step(1);
        check("single_busy_t13", int'(busy), 0);
        check("single_fin_cycle", (fin_q.size() > 0) ? fin_q[0] : -1, t + 12);
        drain("single", 50);

        // Table-driven fairness vectors, one-byte packets with data 0x10+i
        for (int e = 0; e < 7; e++) begin
            clear_logs();
            for (int i = 0; i < N; i++) begin
                if (tbl[e].mask[i]) srcq[i].push_back({1'b1, 8'h10 + 8'(i)});
            end
            drain($sformatf("tbl%0d", e), 300);
            check($sformatf("tbl%0d_count", e), str_q.size(), int'(tbl[e].n));
            for (int j = 0; j < int'(tbl[e].n) && j < str_q.size(); j++) begin
                g = int'(tbl[e].order[15-4*j -: 4]);
                check($sformatf("tbl%0d_gid%0d", e, j), str_q[j].gid, g);
                check($sformatf("tbl%0d_data%0d", e, j), str_q[j].data, 8'h10 + g);
            end
        end

        // Atomicity and burst cap: req1 12-byte packet, req2 2-byte packet
        clear_logs();
        exp_q.delete();
        for (int k = 0; k < 12; k++) srcq[1].push_back({(k == 11), 8'h40 + 8'(k)});
        srcq[2].push_back(9'h080);
        srcq[2].push_back(9'h181);
        for (int k = 0; k < 8; k++) exp_q.push_back('{gid: 1, data: 8'h40 + k, gap: (k == 0) ? 0 : 2});
        exp_q.push_back('{gid: 2, data: 8'h80, gap: 3});
        exp_q.push_back('{gid: 2, data: 8'h81, gap: 2});
        for (int k = 8; k < 12; k++) exp_q.push_back('{gid: 1, data: 8'h40 + k, gap: (k == 8) ? 3 : 2});
        drain("atomic", 600);
        check("atomic_count", str_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < str_q.size(); j++) begin
            check($sformatf("atomic_gid%0d", j), str_q[j].gid, exp_q[j].gid);
            check($sformatf("atomic_data%0d", j), str_q[j].data, exp_q[j].data);
            if (j > 0 && j - 1 < fin_q.size())
                check($sformatf("atomic_gap%0d", j), str_q[j].cyc - fin_q[j-1], exp_q[j].gap);
        end

        // Back-to-back: 3-byte packet, each strobe 2 cycles after finish
        clear_logs();
        srcq[3].push_back(9'h0A0);
        srcq[3].push_back(9'h0A1);
        srcq[3].push_back(9'h1A2);
        drain("b2b", 200);
        check("b2b_count", str_q.size(), 3);
        for (int j = 0; j < 3 && j < str_q.size(); j++) begin
            check($sformatf("b2b_data%0d", j), str_q[j].data, 8'hA0 + j);
            check($sformatf("b2b_gid%0d", j), str_q[j].gid, 3);
            if (j > 0 && j - 1 < fin_q.size())
                check($sformatf("b2b_gap%0d", j), str_q[j].cyc - fin_q[j-1], 2);
        end

        // Watchdog: stub silent; req0 then req2 each time out
        clear_logs();
        stub_on = 1'b0;
        srcq[2].push_back(9'h122);
        srcq[0].push_back(9'h120);
        s = 0;
        while (err_q.size() < 2 && s < 400) begin
            step(1);
            s++;
        end
        step(4);
        stub_on = 1'b1;
        check("wd_err_count", err_q.size(), 2);
        check("wd_strobe_count", str_q.size(), 2);
        check("wd_fin_count", fin_q.size(), 0);
        if (err_q.size() == 2 && str_q.size() == 2) begin
            check("wd_gid0", str_q[0].gid, 0);
            check("wd_data0", str_q[0].data, 8'h20);
            check("wd_err0_cycle", err_q[0], str_q[0].cyc + 65);
            check("wd_gid1", str_q[1].gid, 2);
            check("wd_strobe1_cycle", str_q[1].cyc, err_q[0] + 2);
            check("wd_err1_cycle", err_q[1], str_q[1].cyc + 65);
        end
        drain("wd", 50);

        // tx_finish coincides with expiry: normal release, no error
        clear_logs();
        stub_delay = 64;
        srcq[1].push_back(9'h131);
        drain("wd_coincide", 200);
        check("wd_coincide_err", err_q.size(), 0);
        check("wd_coincide_fin", fin_q.size(), 1);
        if (fin_q.size() == 1 && str_q.size() == 1)
            check("wd_coincide_fin_cycle", fin_q[0], str_q[0].cyc + 64);

        // One cycle too late: watchdog wins, single-cycle error pulse
        clear_logs();
        stub_delay = 65;
        srcq[1].push_back(9'h132);
        drain("wd_late", 200);
        step(4);
        check("wd_late_err", err_q.size(), 1);
        check("wd_late_strobes", str_q.size(), 1);
        if (err_q.size() == 1 && str_q.size() == 1)
            check("wd_late_err_cycle", err_q[0], str_q[0].cyc + 65);
        stub_delay = 10;

        // Reset mid-WAIT
        clear_logs();
        srcq[2].push_back(9'h15A);
        wait_strobes("rstmid", 1, 50);
        step(3);
        check("rstmid_pre_gid", int'(grant_id), 2);
        check("rstmid_pre_data", int'(tx_data_in), 8'h5A);
        check("rstmid_pre_busy", int'(busy), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rstmid_req_ready", int'(req_ready), 0);
        check("rstmid_tx_data_en", int'(tx_data_en), 0);
        check("rstmid_tx_data_in", int'(tx_data_in), 0);
        check("rstmid_grant_id", int'(grant_id), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_timeout_err", int'(timeout_err), 0);
        clear_logs();
        srcq[3].push_back(9'h163);
        srcq[0].push_back(9'h160);
        drain("rstmid_after", 200);
        check("rstmid_count", str_q.size(), 2);
        if (str_q.size() == 2) begin
            check("rstmid_gid0", str_q[0].gid, 0);
            check("rstmid_data0", str_q[0].data, 8'h60);
            check("rstmid_gid1", str_q[1].gid, 3);
            check("rstmid_data1", str_q[1].data, 8'h63);
        end

        check("ready_onehot_violations", onehot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte-stream requesters. Round-robin arbitration with packet atomicity: a granted requester keeps the serializer until it flags its last byte or hits MAX_BURST bytes. Drives the serializer's tx_data_en/tx_data_in strobe and waits for its tx_finish pulse before the next byte. A watchdog releases a stalled grant. Sits between application byte sources and uart_tx; baud timing stays inside uart_tx/baud_gen.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 8, max bytes per grant before forced rotation (1..255)
TIMEOUT, 1048576, clk_in cycles a grant may stall in ACCEPT or WAIT before forced release

Ports:
clk_in  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  N_REQ  per-requester last-byte-of-packet flag, qualified by valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
tx_data_en  out  1  one-cycle load strobe to uart_tx
tx_data_in  out  8  byte to uart_tx, stable from strobe until tx_finish
tx_finish  in  1  one-cycle pulse from uart_tx after the stop bit
grant_id  out  clog2(N_REQ)  current/last granted requester
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Clock is clk_in; reset is synchronous and active-high on rst. Reset mid-operation aborts immediately: no further strobe; uart_tx state is not the arbiter's concern.
- Reset values: req_ready=0, tx_data_en=0, tx_data_in=0, grant_id=0, busy=0, timeout_err=0, state=IDLE, burst_cnt=0, rr pointer=N_REQ-1 (requester 0 wins first).
- States: IDLE, ACCEPT, START, WAIT.
- IDLE: if any req_valid, pick first valid index scanning pointer+1, pointer+2, ... mod N_REQ; register grant_id; -> ACCEPT, burst_cnt=0. Decision is made in the same cycle valid is seen.
- ACCEPT: req_ready[grant_id]=1 (registered output, all other bits 0). Transfer when req_valid[grant_id] is also high: capture byte into tx_data_in and last flag; -> START. Otherwise stay; watchdog runs.
- START: tx_data_en=1 for exactly one cycle; -> WAIT.
- WAIT: on tx_finish: burst_cnt+1; if captured last or burst_cnt+1==MAX_BURST then pointer=grant_id and -> IDLE, else -> ACCEPT (same grant).
- tx_finish outside WAIT is ignored.
- Latency: valid seen in IDLE at cycle t -> ready at t+1 -> strobe at t+2 (if valid held). In a burst, tx_finish at f -> ready at f+1 -> next strobe at f+2.
- Watchdog: counter clears on entering ACCEPT or WAIT and counts while there. Reaching TIMEOUT: pulse timeout_err, pointer=grant_id, -> IDLE. tx_finish in the same cycle as expiry wins: normal transition, no error.
- Requests from non-granted requesters have no effect until release. Valid drop mid-packet holds the grant (only the watchdog breaks it).
- MAX_BURST=1 gives byte-level round-robin.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE/ACCEPT/START/WAIT) and a clog2 function for grant width.
- One sub-module: rr_pick, combinational (req vector, pointer) -> (found, index), instantiated once.

Test Plan:
- Single request: req0 sends 0x0E with last=1, uart_tx stub finishes 10 cycles after strobe -> one tx_data_en pulse at t+2, tx_data_in=0x0E; busy returns low the cycle after finish; pointer=0.
- Fairness: all 4 valid, each sends 1-byte packets (last=1) with data 0x10+i -> grant order 0,1,2,3,0; no two req_ready bits ever high together.
- Atomicity and cap: req1 sends a 12-byte packet (last on byte 12) with MAX_BURST=8 while req2 is valid -> 8 bytes from req1, then req2's packet, then req1's remaining 4.
- Back-to-back timing: 3-byte packet -> each strobe exactly 2 cycles after the previous tx_finish.
- Watchdog: TIMEOUT=64, stub never asserts tx_finish -> timeout_err pulses at cycle 64 in WAIT, grant rotates to the next valid requester; repeat with tx_finish coinciding with expiry -> no error.
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs at reset values next cycle, grant_id=0, next request from req3 and req0 simultaneously grants req0.
